// File: rtl/eth_pkg.sv
// eth_pkg: shared types and constants for the RMII receive framer.
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    DATA,
    CHECK,
    DROP
  } rx_state_t;

  localparam logic [1:0]  PREAMBLE_DIBIT          = 2'b01;
  localparam logic [1:0]  SFD_DIBIT               = 2'b11;

  localparam int          MIN_PREAMBLE_DIBITS_DEF = 8;
  localparam int          MIN_FRAME_BYTES_DEF     = 64;
  localparam int          MAX_FRAME_BYTES_DEF     = 1522;
  localparam logic [31:0] CRC_RESIDUE_DEF         = 32'h2144DF1C;

  // frame_err bit positions: {align, oversize, runt}
  localparam int          ERR_RUNT                = 0;
  localparam int          ERR_OVERSIZE            = 1;
  localparam int          ERR_ALIGN               = 2;

endpackage

// File: rtl/eth_dibit_packer.sv
// eth_dibit_packer: packs RMII dibits LSB-first into bytes and exposes the
// dibit phase so the framer can detect a frame ending mid-byte.
module eth_dibit_packer
  import eth_pkg::*;
(
  input  logic       eth_clk,
  input  logic       rst_in,
  input  logic       clr,
  input  logic       en,
  input  logic [1:0] dibit,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic [1:0] phase
);

  logic [5:0] shift_q;

  // Phase counter and byte strobe; the fourth dibit completes a byte
  always_ff @(posedge eth_clk or negedge rst_in) begin
    if (!rst_in) begin
      phase      <= 2'd0;
      byte_valid <= 1'b0;
      byte_out   <= 8'd0;
    end else begin
      byte_valid <= 1'b0;
      if (clr) begin
        phase <= 2'd0;
      end else if (en) begin
        phase <= phase + 2'd1;
        if (phase == 2'd3) begin
          byte_out   <= {dibit, shift_q};
          byte_valid <= 1'b1;
        end
      end
    end
  end

  // Data shift register: earliest dibit ends up in the low bits
  always_ff @(posedge eth_clk) begin
    if (en) shift_q <= {dibit, shift_q[5:2]};
  end

endmodule

// File: rtl/eth_rmii_rx_framer.sv
// eth_rmii_rx_framer: RMII receive framer. Detects preamble/SFD, feeds
// eth_crc32 with frame dibits, assembles bytes and reports frame status.
// Optional build macro ETH_RX_STATS_EN adds saturating frame counters.
module eth_rmii_rx_framer
  import eth_pkg::*;
#(
  parameter int          MIN_PREAMBLE_DIBITS = MIN_PREAMBLE_DIBITS_DEF,
  parameter int          MIN_FRAME_BYTES     = MIN_FRAME_BYTES_DEF,
  parameter int          MAX_FRAME_BYTES     = MAX_FRAME_BYTES_DEF,
  parameter logic [31:0] CRC_RESIDUE         = CRC_RESIDUE_DEF
) (
  input  logic        eth_clk,
  input  logic        rst_in,
  input  logic        eth_crsdv,
  input  logic [1:0]  eth_rxd,
  input  logic [31:0] crc_in,
  output logic        crc_rst,
  output logic        crc_active,
  output logic [1:0]  crc_rxd,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [2:0]  frame_err
`ifdef ETH_RX_STATS_EN
  ,
  output logic [15:0] stat_good,
  output logic [15:0] stat_crc_err,
  output logic [15:0] stat_len_err
`endif
);

  localparam logic [7:0]  MIN_PRE = 8'(MIN_PREAMBLE_DIBITS);
  localparam logic [10:0] MIN_LEN = 11'(MIN_FRAME_BYTES);
  localparam logic [10:0] MAX_LEN = 11'(MAX_FRAME_BYTES);

  logic        crsdv_q;
  logic [1:0]  rxd_q;
  rx_state_t   state_q, state_d;
  logic [7:0]  pre_cnt_q;
  logic [10:0] byte_cnt_q;
  logic        align_q;
  logic        chk_cnt_q;
  logic        idle_cnt_q;
  logic        armed_q;
  logic        sfd, take, enter_check, arm;
  logic        done_d, ok_d;
  logic [2:0]  err_d;
  logic        runt;
  logic [1:0]  phase;

  assign runt = (byte_cnt_q < MIN_LEN);

  // Carrier sense input register
  always_ff @(posedge eth_clk or negedge rst_in) begin
    if (!rst_in) crsdv_q <= 1'b0;
    else         crsdv_q <= eth_crsdv;
  end

  // Dibit input register (pure data)
  always_ff @(posedge eth_clk) begin
    rxd_q <= eth_rxd;
  end

  // State register
  always_ff @(posedge eth_clk or negedge rst_in) begin
    if (!rst_in) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state and per-cycle control decisions
  always_comb begin
    state_d     = state_q;
    sfd         = 1'b0;
    take        = 1'b0;
    enter_check = 1'b0;
    arm         = 1'b0;
    done_d      = 1'b0;
    ok_d        = 1'b0;
    err_d       = 3'b000;
    case (state_q)
      IDLE: begin
        // Until the line has been seen idle since reset, a burst in
        // progress must not be mistaken for a new preamble.
        if (!armed_q)                                   state_d = DROP;
        else if (crsdv_q && rxd_q == PREAMBLE_DIBIT)    state_d = PREAMBLE;
      end
      PREAMBLE: begin
        if (!crsdv_q) begin
          state_d = DROP;
        end else if (rxd_q == PREAMBLE_DIBIT) begin
          state_d = PREAMBLE;
        end else if (rxd_q == SFD_DIBIT && pre_cnt_q >= MIN_PRE) begin
          state_d = DATA;
          sfd     = 1'b1;
        end else begin
          state_d = DROP;
        end
      end
      DATA: begin
        if (byte_cnt_q > MAX_LEN) begin
          state_d             = DROP;
          done_d              = 1'b1;
          err_d[ERR_OVERSIZE] = 1'b1;
        end else if (!crsdv_q) begin
          state_d     = CHECK;
          enter_check = 1'b1;
        end else begin
          take = 1'b1;
        end
      end
      CHECK: begin
        // Second CHECK cycle: the CRC result has settled
        if (chk_cnt_q) begin
          state_d         = DROP;
          done_d          = 1'b1;
          err_d[ERR_ALIGN] = align_q;
          err_d[ERR_RUNT]  = runt;
          ok_d            = (crc_in == CRC_RESIDUE) && !align_q && !runt;
        end
      end
      DROP: begin
        if (!crsdv_q && idle_cnt_q) begin
          state_d = IDLE;
          arm     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Preamble, byte, check and idle counters plus sticky frame flags
  always_ff @(posedge eth_clk or negedge rst_in) begin
    if (!rst_in) begin
      pre_cnt_q  <= 8'd0;
      byte_cnt_q <= 11'd0;
      align_q    <= 1'b0;
      chk_cnt_q  <= 1'b0;
      idle_cnt_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      if (state_q == IDLE)
        pre_cnt_q <= 8'd1;
      else if (state_q == PREAMBLE && rxd_q == PREAMBLE_DIBIT && pre_cnt_q != 8'hFF)
        pre_cnt_q <= pre_cnt_q + 8'd1;

      if (sfd)
        byte_cnt_q <= 11'd0;
      else if (take && phase == 2'd3 && byte_cnt_q != 11'h7FF)
        byte_cnt_q <= byte_cnt_q + 11'd1;

      if (sfd)              align_q <= 1'b0;
      else if (enter_check) align_q <= (phase != 2'd0);

      chk_cnt_q  <= (state_q == CHECK) ? ~chk_cnt_q : 1'b0;
      idle_cnt_q <= (state_q == DROP) && !crsdv_q;
      if (arm) armed_q <= 1'b1;
    end
  end

  // Registered CRC feed and frame status outputs
  always_ff @(posedge eth_clk or negedge rst_in) begin
    if (!rst_in) begin
      crc_rst    <= 1'b0;
      crc_active <= 1'b0;
      crc_rxd    <= 2'b00;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      frame_err  <= 3'b000;
    end else begin
      crc_rst    <= sfd;
      crc_active <= take;
      if (take) crc_rxd <= rxd_q;
      frame_done <= done_d;
      frame_ok   <= ok_d;
      frame_err  <= err_d;
    end
  end

  eth_dibit_packer u_packer (
    .eth_clk    (eth_clk),
    .rst_in     (rst_in),
    .clr        (sfd),
    .en         (take),
    .dibit      (rxd_q),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .phase      (phase)
  );

`ifdef ETH_RX_STATS_EN
  // Saturating per-category frame counters; length errors take precedence
  always_ff @(posedge eth_clk or negedge rst_in) begin
    if (!rst_in) begin
      stat_good    <= 16'd0;
      stat_crc_err <= 16'd0;
      stat_len_err <= 16'd0;
    end else if (done_d) begin
      if (err_d[ERR_RUNT] || err_d[ERR_OVERSIZE]) begin
        if (stat_len_err != 16'hFFFF) stat_len_err <= stat_len_err + 16'd1;
      end else if (ok_d) begin
        if (stat_good != 16'hFFFF) stat_good <= stat_good + 16'd1;
      end else begin
        if (stat_crc_err != 16'hFFFF) stat_crc_err <= stat_crc_err + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_eth_rmii_rx_framer.sv
// tb_eth_rmii_rx_framer: directed frames against a frame-level model of the
// receiver, with an eth_crc32 stand-in driving crc_in.
`timescale 1ns/1ps
module tb_eth_rmii_rx_framer;

  localparam logic [31:0] POLY = 32'hEDB88320;

  logic        eth_clk = 1'b0;
  logic        rst_in;
  logic        eth_crsdv;
  logic [1:0]  eth_rxd;
  logic [31:0] crc_in;
  logic        crc_rst, crc_active;
  logic [1:0]  crc_rxd;
  logic [7:0]  byte_out;
  logic        byte_valid, frame_done, frame_ok;
  logic [2:0]  frame_err;

  eth_rmii_rx_framer dut (
    .eth_clk    (eth_clk),
    .rst_in     (rst_in),
    .eth_crsdv  (eth_crsdv),
    .eth_rxd    (eth_rxd),
    .crc_in     (crc_in),
    .crc_rst    (crc_rst),
    .crc_active (crc_active),
    .crc_rxd    (crc_rxd),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .frame_done (frame_done),
    .frame_ok   (frame_ok),
    .frame_err  (frame_err)
  );

  always #10 eth_clk = ~eth_clk;

  // ---------------- eth_crc32 stand-in (reflected CRC-32, dibit serial)
  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 2; b++) r = (r[0] ^ d[b]) ? ((r >> 1) ^ POLY) : (r >> 1);
    return r;
  endfunction

  logic [31:0] crc_reg = 32'h0;
  always @(posedge eth_clk) begin
    if (crc_rst)         crc_reg <= 32'hFFFFFFFF;
    else if (crc_active) crc_reg <= crc_dibit(crc_reg, crc_rxd);
  end
  assign crc_in = ~crc_reg;

  // ---------------- frame buffer and byte-wise CRC for FCS generation
  logic [7:0] frm [0:2047];

  function automatic logic [31:0] crc32_bytes(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, frm[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
    end
    return ~c;
  endfunction

  // ---------------- expectations and bookkeeping
  logic [7:0]  exp_bytes[$];
  logic [3:0]  exp_done[$];      // {ok, align, oversize, runt}
  string       pend_name[$];
  logic [63:0] pend_got[$];
  logic [63:0] pend_exp[$];

  int   vectors = 0;
  int   fails   = 0;
  int   nbv = 0, ndone = 0, nrst = 0;
  int   s_bv, s_done, s_rst;
  logic       last_ok  = 1'b0;
  logic [2:0] last_err = 3'b000;
  bit         mute = 1'b0;

  logic [7:0]  eb;
  logic [3:0]  ed;
  logic [63:0] pg, pe;
  string       pn;

  task automatic post(input string nm, input logic [63:0] g, input logic [63:0] e);
    pend_name.push_back(nm);
    pend_got.push_back(g);
    pend_exp.push_back(e);
  endtask

  // Single compare process, sampling on the falling edge
  always @(negedge eth_clk) begin
    while (pend_name.size() > 0) begin
      pn = pend_name.pop_front();
      pg = pend_got.pop_front();
      pe = pend_exp.pop_front();
      vectors++;
      if (pg !== pe) begin
        fails++;
        $display("FAIL %s: got %0h, expected %0h", pn, pg, pe);
      end
    end
    if (crc_rst) nrst++;
    if (crc_rst || crc_active) begin
      vectors++;
      if (crc_rst && crc_active) begin
        fails++;
        $display("FAIL crc_rst_active_exclusive: got both 1, expected at most one");
      end
    end
    if (byte_valid) begin
      nbv++;
      if (!mute) begin
        vectors++;
        if (exp_bytes.size() == 0) begin
          fails++;
          $display("FAIL byte_valid: got strobe with byte %02h, expected none", byte_out);
        end else begin
          eb = exp_bytes.pop_front();
          if (byte_out !== eb) begin
            fails++;
            $display("FAIL byte_out: got %02h, expected %02h", byte_out, eb);
          end
        end
      end
    end
    if (frame_done) begin
      ndone++;
      last_ok  = frame_ok;
      last_err = frame_err;
      if (!mute) begin
        vectors++;
        if (exp_done.size() == 0) begin
          fails++;
          $display("FAIL frame_done: got strobe ok=%0b err=%03b, expected none", frame_ok, frame_err);
        end else begin
          ed = exp_done.pop_front();
          if ({frame_ok, frame_err} !== ed) begin
            fails++;
            $display("FAIL frame_status: got ok=%0b err=%03b, expected ok=%0b err=%03b",
                     frame_ok, frame_err, ed[3], ed[2:0]);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers
  task automatic drive(input logic dv, input logic [1:0] d);
    @(negedge eth_clk);
    eth_crsdv = dv;
    eth_rxd   = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'b00);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int k = 0; k < 4; k++) drive(1'b1, b[2*k +: 2]);
  endtask

  task automatic build(input int n, input int seed);
    logic [31:0] fcs;
    for (int i = 0; i < n - 4; i++) frm[i] = 8'((i * 37 + seed * 13 + 5) ^ (i >> 2));
    fcs = crc32_bytes(n - 4);
    frm[n-4] = fcs[7:0];
    frm[n-3] = fcs[15:8];
    frm[n-2] = fcs[23:16];
    frm[n-1] = fcs[31:24];
  endtask

  task automatic snap();
    s_bv   = nbv;
    s_done = ndone;
    s_rst  = nrst;
  endtask

  // Frame-level model: derive expected strobes from length, FCS and framing,
  // then drive preamble, SFD, bytes, trailing dibits and an idle gap.
  task automatic send_frame(input string nm, input int npre, input int nbytes, input int extra);
    logic fcs_ok, runt, align;
    int   nexp;
    if (npre >= 8) begin
      nexp = (nbytes > 1522) ? 1523 : nbytes;
      for (int i = 0; i < nexp; i++) exp_bytes.push_back(frm[i]);
      if (nbytes > 1522) begin
        exp_done.push_back(4'b0010);
      end else begin
        fcs_ok = (crc32_bytes(nbytes - 4) ==
                  {frm[nbytes-1], frm[nbytes-2], frm[nbytes-3], frm[nbytes-4]});
        runt   = (nbytes < 64);
        align  = (extra % 4) != 0;
        exp_done.push_back({fcs_ok && !runt && !align, align, 1'b0, runt});
      end
    end
    drive(1'b1, 2'b00);
    for (int i = 0; i < npre; i++) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
    for (int i = 0; i < nbytes; i++) send_byte(frm[i]);
    for (int i = 0; i < extra; i++) drive(1'b1, 2'b10);
    idle(24);
    post({nm, "_outstanding"}, 64'(exp_bytes.size() + exp_done.size()), 64'd0);
  endtask

  // ---------------- watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // ---------------- directed sequence
  initial begin
    rst_in    = 1'b0;
    eth_crsdv = 1'b0;
    eth_rxd   = 2'b00;

    // Pin the byte CRC model to the standard check value
    for (int i = 0; i < 9; i++) frm[i] = 8'h31 + 8'(i);
    post("crc_model_check", 64'(crc32_bytes(9)), 64'hCBF43926);

    repeat (3) @(negedge eth_clk);
    post("reset_outputs", 64'({crc_rst, crc_active, crc_rxd, byte_out, byte_valid,
                               frame_done, frame_ok, frame_err}), 64'd0);
    rst_in = 1'b1;
    idle(8);

    // Standard preamble (7 x 0x55 + 0xD5 = 31 x 01 then 11), 64-byte good frame
    build(64, 1);
    snap();
    send_frame("good64", 31, 64, 0);
    post("good64_crc_rst", 64'(nrst - s_rst), 64'd1);
    post("good64_bytes", 64'(nbv - s_bv), 64'd64);
    post("good64_done", 64'(ndone - s_done), 64'd1);
    post("good64_status", 64'({last_ok, last_err}), 64'b1000);

    // Same frame, one payload bit flipped
    build(64, 1);
    frm[20] = frm[20] ^ 8'h08;
    snap();
    send_frame("badcrc", 31, 64, 0);
    post("badcrc_done", 64'(ndone - s_done), 64'd1);
    post("badcrc_status", 64'({last_ok, last_err}), 64'b0000);

    // Short preamble: 3 x 01 then 11
    build(16, 2);
    snap();
    send_frame("pre3", 3, 16, 0);
    post("pre3_crc_rst", 64'(nrst - s_rst), 64'd0);
    post("pre3_bytes", 64'(nbv - s_bv), 64'd0);
    post("pre3_done", 64'(ndone - s_done), 64'd0);

    // One dibit below the minimum preamble
    build(16, 3);
    snap();
    send_frame("pre7", 7, 16, 0);
    post("pre7_crc_rst", 64'(nrst - s_rst), 64'd0);
    post("pre7_done", 64'(ndone - s_done), 64'd0);

    // Exactly the minimum preamble
    build(64, 4);
    snap();
    send_frame("pre8", 8, 64, 0);
    post("pre8_done", 64'(ndone - s_done), 64'd1);
    post("pre8_status", 64'({last_ok, last_err}), 64'b1000);

    // 60-byte frame with valid FCS: runt
    build(60, 5);
    snap();
    send_frame("runt60", 31, 60, 0);
    post("runt60_bytes", 64'(nbv - s_bv), 64'd60);
    post("runt60_status", 64'({last_ok, last_err}), 64'b0001);

    // Valid frame with two trailing dibits: alignment error
    build(64, 6);
    snap();
    send_frame("align", 31, 64, 2);
    post("align_bytes", 64'(nbv - s_bv), 64'd64);
    post("align_status", 64'({last_ok, last_err}), 64'b0100);

    // 1530-byte frame: oversize after byte 1523, then a good frame
    build(1530, 7);
    snap();
    send_frame("over", 31, 1530, 0);
    post("over_bytes", 64'(nbv - s_bv), 64'd1523);
    post("over_done", 64'(ndone - s_done), 64'd1);
    post("over_status", 64'({last_ok, last_err}), 64'b0010);
    build(64, 8);
    snap();
    send_frame("after_over", 31, 64, 0);
    post("after_over_status", 64'({last_ok, last_err}), 64'b1000);

    // Reset mid-payload, released while CRS_DV is still high
    build(64, 9);
    mute = 1'b1;
    drive(1'b1, 2'b00);
    for (int i = 0; i < 31; i++) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
    for (int i = 0; i < 20; i++) send_byte(frm[i]);
    for (int k = 0; k < 4 * 44; k++) begin
      drive(1'b1, frm[20 + k / 4][2 * (k % 4) +: 2]);
      if (k == 0) rst_in = 1'b0;
      if (k == 3) begin
        post("midreset_outputs", 64'({crc_rst, crc_active, crc_rxd, byte_out, byte_valid,
                                      frame_done, frame_ok, frame_err}), 64'd0);
        mute = 1'b0;
        snap();
      end
      if (k == 6) rst_in = 1'b1;
    end
    idle(24);
    post("reset_bytes", 64'(nbv - s_bv), 64'd0);
    post("reset_done", 64'(ndone - s_done), 64'd0);
    post("reset_crc_rst", 64'(nrst - s_rst), 64'd0);
    build(64, 10);
    snap();
    send_frame("after_reset", 31, 64, 0);
    post("after_reset_done", 64'(ndone - s_done), 64'd1);
    post("after_reset_status", 64'({last_ok, last_err}), 64'b1000);

    repeat (4) @(negedge eth_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
